// File: rtl/load_store_unit.sv
// Load/store unit for a single-ported word memory: sub-word stores become read-modify-write,
// loads are lane-extracted and extended, misaligned or out-of-range requests error out with no strobes.

module lsu_byte_lane (
  input  logic       sel,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] merged
);
  assign merged = sel ? new_byte : old_byte;
endmodule

module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read_data
);
  localparam int          NUM_LANES   = 4;
  localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] word_q;
  logic        accept;
  logic        err_now;
  logic [31:0] load_ext;
  logic [31:0] shifted;
  logic [31:0] merged;
  logic [NUM_LANES-1:0] lane_sel;

  assign accept = req_valid && (state == IDLE);

  // Request check runs on the raw inputs but only feeds the state/err registers.
  always_comb begin
    err_now = 1'b0;
    case (req_size)
      2'b01:   err_now = req_addr[0];
      2'b10:   err_now = (req_addr[1:0] != 2'b00);
      2'b11:   err_now = 1'b1;
      default: err_now = 1'b0;
    endcase
    if ({2'b00, req_addr[31:2]} >= MEM_WORDS_U) err_now = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (err_now)                            state_nxt = RESP;
          else if (req_write && req_size == 2'b10) state_nxt = WR;
          else                                    state_nxt = RD;
        end
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = req_q.write ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Load path: shift the addressed lane to bit 0, then extend.
  assign shifted = mem_read_data >> {req_q.addr[1:0], 3'b000};

  always_comb begin
    case (req_q.size)
      2'b00:   load_ext = {{24{req_q.sgn & shifted[7]}},  shifted[7:0]};
      2'b01:   load_ext = {{16{req_q.sgn & shifted[15]}}, shifted[15:0]};
      default: load_ext = mem_read_data;
    endcase
  end

  // Store path: each byte lane either keeps the old memory byte or takes the store byte.
  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [1:0] LANE = 2'(i);
      logic [7:0] new_byte;

      always_comb begin
        case (req_q.size)
          2'b00: begin
            lane_sel[i] = (req_q.addr[1:0] == LANE);
            new_byte    = req_q.wdata[7:0];
          end
          2'b01: begin
            lane_sel[i] = (req_q.addr[1] == LANE[1]);
            new_byte    = req_q.wdata[8*(i%2) +: 8];
          end
          default: begin
            lane_sel[i] = 1'b1;
            new_byte    = req_q.wdata[8*i +: 8];
          end
        endcase
      end

      lsu_byte_lane u_lane (
        .sel      (lane_sel[i]),
        .old_byte (mem_read_data[8*i +: 8]),
        .new_byte (new_byte),
        .merged   (merged[8*i +: 8])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      word_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_q   <= '{write: req_write, size: req_size, sgn: req_signed,
                     addr: req_addr, wdata: req_wdata};
        err_q   <= err_now;
        rdata_q <= '0;
        word_q  <= req_wdata;
      end
      if (state == CAP) begin
        if (req_q.write) word_q  <= merged;
        else             rdata_q <= load_ext;
      end
    end
  end

  // All outputs decode registered state only.
  assign req_ready        = (state == IDLE);
  assign resp_valid       = (state == RESP);
  assign resp_err         = (state == RESP) && err_q;
  assign resp_rdata       = (state == RESP) ? rdata_q : '0;
  assign mem_read_enable  = (state == RD);
  assign mem_write_enable = (state == WR);
  assign mem_address      = (state == RD || state == CAP || state == WR) ?
                            {2'b00, req_q.addr[31:2]} : '0;
  assign mem_write_data   = (state == WR) ? word_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed literal cases plus randomized traffic against a
// cycle-count/array reference model, checked every cycle on the falling edge.

module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        mem_init;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
      mem_read_data <= '0;
    end else begin
      if (mem_write_enable) mem[mem_address[7:0]] <= mem_write_data;
      if (mem_read_enable)  mem_read_data <= mem[mem_address[7:0]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: busy countdown; response on the last busy cycle, read on the first
  // busy cycle of a load/RMW, write on the cycle just before the response.
  int          cnt = 0;
  int          m_lat;
  logic        m_err, m_write;
  logic [31:0] m_rdata, m_word, m_idx;

  always @(negedge clk) begin
    logic [31:0] a, w, lane;
    int sh;
    if (rst) begin
      cnt = 0;
      chk("rst_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_mem_re", mem_read_enable, 0);
      chk("rst_mem_we", mem_write_enable, 0);
      chk("rst_mem_addr", mem_address, 0);
      chk("rst_mem_wdata", mem_write_data, 0);
    end else begin
      chk("no_dual_strobe", 32'(mem_read_enable && mem_write_enable), 0);
      if (cnt == 0) begin
        chk("idle_ready", req_ready, 1);
        chk("idle_resp_valid", resp_valid, 0);
        chk("idle_mem_re", mem_read_enable, 0);
        chk("idle_mem_we", mem_write_enable, 0);
        if (req_valid) begin
          a = req_addr;
          m_write = req_write;
          m_idx = {2'b00, a[31:2]};
          m_err = (req_size == 3) || (req_size == 1 && a[0]) ||
                  (req_size == 2 && a[1:0] != 0) || (m_idx >= 256);
          m_lat = m_err ? 1 : !m_write ? 3 : (req_size == 2) ? 2 : 4;
          w  = m_err ? 32'h0 : ref_mem[a[9:2]];
          sh = 8 * int'(a[1:0]);
          lane = w;
          if (req_size == 0) begin
            lane = (w >> sh) & 32'hFF;
            if (req_signed && lane[7]) lane = lane | 32'hFFFF_FF00;
          end else if (req_size == 1) begin
            lane = (w >> sh) & 32'hFFFF;
            if (req_signed && lane[15]) lane = lane | 32'hFFFF_0000;
          end
          m_rdata = (m_err || m_write) ? 32'h0 : lane;
          if (req_size == 0)
            m_word = (w & ~(32'hFF << sh)) | ((req_wdata & 32'hFF) << sh);
          else if (req_size == 1)
            m_word = (w & ~(32'hFFFF << sh)) | ((req_wdata & 32'hFFFF) << sh);
          else
            m_word = req_wdata;
          cnt = m_lat;
        end
      end else begin
        chk("busy_ready", req_ready, 0);
        chk("resp_valid", resp_valid, 32'(cnt == 1));
        if (cnt == 1) begin
          chk("resp_err", resp_err, 32'(m_err));
          chk("resp_rdata", resp_rdata, m_rdata);
        end
        chk("mem_re", mem_read_enable, 32'(!m_err && m_lat >= 3 && cnt == m_lat));
        if (!m_err && m_lat >= 3 && cnt == m_lat) chk("rd_addr", mem_address, m_idx);
        chk("mem_we", mem_write_enable, 32'(!m_err && m_write && cnt == 2));
        if (!m_err && m_write && cnt == 2) begin
          chk("wr_addr", mem_address, m_idx);
          chk("wr_data", mem_write_data, m_word);
          ref_mem[m_idx[7:0]] = m_word;
        end
        cnt--;
      end
    end
  end

  // Issues one request from an idle DUT and pins latency/result to hand-computed values.
  task automatic run_req(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat = 0;
    logic [31:0] rd = 32'hx;
    logic er = 1'bx;
    req_valid = 1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk); #2;
    req_valid = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      if (resp_valid) begin lat = i; rd = resp_rdata; er = resp_err; end
    end
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_rdata"}, rd, exp_rd);
    chk({nm, "_err"}, 32'(er), 32'(exp_err));
    @(posedge clk); #2;
  endtask

  initial begin
    int nresp, c;
    logic [31:0] got [4];
    int t [4];
    rst = 1; mem_init = 1;
    req_valid = 0; req_write = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[0] = 32'h0BAD_F00D;
    ref_mem[1] = 32'hAABB_CCDD;
    ref_mem[3] = 32'h80FF_1234;
    ref_mem[4] = 32'h5566_7788;
    repeat (3) @(posedge clk);
    #2 mem_init = 0; rst = 0;

    run_req("ldb_s_0e", 0, 2'b00, 1, 32'h0E, 0, 32'hFFFF_FFFF, 0, 3);
    run_req("ldb_u_0f", 0, 2'b00, 0, 32'h0F, 0, 32'h0000_0080, 0, 3);
    run_req("ldh_s_0c", 0, 2'b01, 1, 32'h0C, 0, 32'h0000_1234, 0, 3);
    run_req("ldh_s_0e", 0, 2'b01, 1, 32'h0E, 0, 32'hFFFF_80FF, 0, 3);
    run_req("sth_06",   1, 2'b01, 0, 32'h06, 32'h1234, 0, 0, 4);
    run_req("ldw_04",   0, 2'b10, 0, 32'h04, 0, 32'h1234_CCDD, 0, 3);
    run_req("stw_08",   1, 2'b10, 0, 32'h08, 32'hDEAD_BEEF, 0, 0, 2);
    run_req("ldw_08",   0, 2'b10, 1, 32'h08, 0, 32'hDEAD_BEEF, 0, 3);
    run_req("err_w05",  0, 2'b10, 0, 32'h05, 0, 0, 1, 1);
    run_req("err_h03",  0, 2'b01, 0, 32'h03, 0, 0, 1, 1);
    run_req("err_sz3",  0, 2'b11, 0, 32'h00, 0, 0, 1, 1);
    run_req("err_oor",  0, 2'b10, 0, 32'h400, 0, 0, 1, 1);

    // Reset during the write cycle of a byte store must kill the write and the response.
    req_valid = 1; req_write = 1; req_size = 2'b00; req_signed = 0; req_addr = 32'h11; req_wdata = 32'hAB;
    @(posedge clk); #2 req_valid = 0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("abort_we_before", mem_write_enable, 1);
    #1 rst = 1;
    #1 chk("abort_we_dropped", mem_write_enable, 0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    #1 chk("abort_ready_after", req_ready, 1);
    run_req("ldw_10_after_abort", 0, 2'b10, 0, 32'h10, 0, 32'h5566_7788, 0, 3);

    // Four loads with req_valid held: responses in order, four cycles apart.
    nresp = 0; c = 0;
    req_valid = 1; req_write = 0; req_size = 2'b10; req_signed = 0; req_addr = 0;
    while (nresp < 4 && c < 40) begin
      @(negedge clk); c++;
      if (resp_valid) begin
        got[nresp] = resp_rdata; t[nresp] = c; nresp++;
        @(posedge clk); #2;
        req_addr = 32'(nresp * 4);
        if (nresp == 4) req_valid = 0;
      end
    end
    req_valid = 0;
    chk("b2b_count", 32'(nresp), 4);
    if (nresp == 4) begin
      chk("b2b_r0", got[0], 32'h0BAD_F00D);
      chk("b2b_r1", got[1], 32'h1234_CCDD);
      chk("b2b_r2", got[2], 32'hDEAD_BEEF);
      chk("b2b_r3", got[3], 32'h80FF_1234);
      for (int i = 1; i < 4; i++) chk("b2b_gap", 32'(t[i] - t[i-1]), 4);
    end

    // Random traffic; the per-cycle model checks everything.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #2;
      req_valid  = ($urandom_range(0, 3) != 0);
      req_write  = $urandom_range(0, 1);
      req_size   = 2'($urandom_range(0, 3));
      req_signed = $urandom_range(0, 1);
      req_addr   = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      req_wdata  = $urandom;
    end
    req_valid = 0;
    repeat (6) @(posedge clk);
    #2;
    begin
      int mism = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
      chk("mem_final_mismatches", 32'(mism), 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
